stoch_maxpool_seq: RTL

STOCH_MAXPOOL_SEQ -- requirements
Module: stoch_maxpool_seq

---
 rtl/stoch_maxpool_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/stoch_maxpool_seq.sv
// Frame sequencer for a stochastic max-pool array: clears the datapath, discards
// warm-up cycles, then integrates signed bitstreams per lane over L cycles.
module stoch_maxpool_seq #(
  parameter int NUM_OUT = 4,
  parameter int LEN_W   = 10,
  parameter int FLUSH   = 2
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           start,
  input  logic                           abort,
  input  logic [LEN_W-1:0]               stream_len,
  input  logic [NUM_OUT-1:0]             y_p,
  input  logic [NUM_OUT-1:0]             y_m,
  output logic                           pool_clr,
  output logic                           src_en,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_OUT*(LEN_W+1)-1:0]   acc
);

  localparam int          AW    = LEN_W + 1;
  localparam int unsigned NLANE = NUM_OUT;
  localparam logic [LEN_W-1:0] WARM_LAST = (FLUSH > 0) ? LEN_W'(FLUSH - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WARM,
    RUN,
    DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [LEN_W-1:0]           cnt_q, cnt_d;
  logic [NUM_OUT-1:0][AW-1:0] acc_q, acc_d;
  logic                       pool_clr_q, pool_clr_d;
  logic                       src_en_q, src_en_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;

    case (state_q)
      IDLE: begin
        if (start && (stream_len != '0)) begin
          state_d = CLEAR;
          len_d   = stream_len;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = (FLUSH > 0) ? WARM : RUN;
          cnt_d   = '0;
        end
      end
      WARM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == WARM_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      RUN: begin
        // Abort wins over terminal count and also suppresses this cycle's update.
        if (abort) begin
          state_d = IDLE;
        end else begin
          for (int unsigned i = 0; i < NLANE; i++) begin
            case ({y_p[i], y_m[i]})
              2'b10:   acc_d[i] = acc_q[i] + AW'(1);
              2'b01:   acc_d[i] = acc_q[i] - AW'(1);
              default: acc_d[i] = acc_q[i];
            endcase
          end
          if (cnt_q == (len_q - LEN_W'(1))) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs decoded from the next state so they are flop outputs aligned with it.
    pool_clr_d = (state_d == CLEAR);
    src_en_d   = (state_d == WARM) || (state_d == RUN);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      pool_clr_q <= 1'b0;
      src_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      pool_clr_q <= pool_clr_d;
      src_en_q   <= src_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pool_clr = pool_clr_q;
  assign src_en   = src_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign acc      = acc_q;

endmodule
